// File: rtl/accum_mem_pkg.sv
// Shared types and helpers for the accumulating per-column output buffer.
package accum_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned SAT_CALC_WIDTH = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_t;

    // Signed add of two sign-extended operands, clipped to the range of a width-bit word.
    function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_add(
        input logic signed [SAT_CALC_WIDTH-1:0] a,
        input logic signed [SAT_CALC_WIDTH-1:0] b,
        input int unsigned                      width
    );
        logic signed [SAT_CALC_WIDTH-1:0] sum;
        logic signed [SAT_CALC_WIDTH-1:0] hi;
        logic signed [SAT_CALC_WIDTH-1:0] lo;
        sum = a + b;
        hi  = (SAT_CALC_WIDTH'(64'sd1) <<< (width - 1)) - SAT_CALC_WIDTH'(64'sd1);
        lo  = -hi - SAT_CALC_WIDTH'(64'sd1);
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/accum_mem_bank.sv
// One channel bank: single write port plus two synchronous read-first read ports.
module accum_mem_bank
    import accum_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
        end else if (re_a) begin
            rdata_a <= mem[raddr_a];
        end
    end

    // Read port B holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_b <= '0;
        end else if (re_b) begin
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/accum_mem_arr.sv
// Per-column output buffer with overwrite / saturating-accumulate writes and a global clear sweep.
module accum_mem_arr
    import accum_mem_pkg::*;
#(
    parameter int unsigned WIDTH_HEIGHT = 4,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    output logic                               busy,
    input  logic [WIDTH_HEIGHT-1:0]            wr_en,
    input  logic [WIDTH_HEIGHT-1:0]            wr_accum,
    input  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0] wr_data,
    input  logic [WIDTH_HEIGHT-1:0]            rd_en,
    input  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0] rd_data,
    output logic [WIDTH_HEIGHT-1:0]            rd_valid,
    output logic [WIDTH_HEIGHT-1:0]            ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = SAT_CALC_WIDTH;

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  sweeping;
    logic                  clr_accept;
    logic                  req_ok;

    assign sweeping   = (state == ST_SWEEP);
    assign clr_accept = (state == ST_IDLE) && clear;
    assign req_ok     = (state == ST_IDLE) && !clear;

    // Clear FSM: one zero write per address across all banks, then back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sweep_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state     <= ST_SWEEP;
                        sweep_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (sweep_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < int'(WIDTH_HEIGHT); i++) begin : g_ch
        logic                  wr_go;
        logic                  rd_go;
        logic                  a_vld;
        logic                  a_accum;
        logic [ADDR_WIDTH-1:0] a_addr;
        logic [DATA_WIDTH-1:0] a_data;
        logic                  c_vld;
        logic [ADDR_WIDTH-1:0] c_addr;
        logic [DATA_WIDTH-1:0] c_data;
        logic [DATA_WIDTH-1:0] qa;
        logic [DATA_WIDTH-1:0] qb;
        logic [DATA_WIDTH-1:0] old_val;
        logic [DATA_WIDTH-1:0] b_res;
        logic signed [CW-1:0]  sum_raw;
        logic signed [CW-1:0]  sum_sat;
        logic                  b_sat;
        logic                  ovf_q;
        logic                  rd_vld_q;
        logic                  bank_we;
        logic [ADDR_WIDTH-1:0] bank_waddr;
        logic [DATA_WIDTH-1:0] bank_wdata;

        assign wr_go = wr_en[i] && req_ok;
        assign rd_go = rd_en[i] && req_ok;

        // Stage A captures the request; stage-B result is kept one cycle for forwarding.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_vld   <= 1'b0;
                a_accum <= 1'b0;
                a_addr  <= '0;
                a_data  <= '0;
                c_vld   <= 1'b0;
                c_addr  <= '0;
                c_data  <= '0;
            end else begin
                a_vld <= wr_go;
                if (wr_go) begin
                    a_accum <= wr_accum[i];
                    a_addr  <= wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    a_data  <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                c_vld  <= a_vld;
                c_addr <= a_addr;
                c_data <= b_res;
            end
        end

        // Stage B: the bank read cannot see a commit on the same edge, so forward it.
        always_comb begin
            old_val    = (c_vld && (c_addr == a_addr)) ? c_data : qa;
            sum_raw    = CW'(signed'(old_val)) + CW'(signed'(a_data));
            sum_sat    = sat_add(CW'(signed'(old_val)), CW'(signed'(a_data)), DATA_WIDTH);
            b_res      = a_accum ? sum_sat[DATA_WIDTH-1:0] : a_data;
            b_sat      = a_vld && a_accum && (sum_sat != sum_raw);
            bank_we    = sweeping || a_vld;
            bank_waddr = sweeping ? sweep_cnt : a_addr;
            bank_wdata = sweeping ? '0 : b_res;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q    <= 1'b0;
                rd_vld_q <= 1'b0;
            end else begin
                rd_vld_q <= rd_go;
                if (clr_accept) begin
                    ovf_q <= 1'b0;
                end else if (b_sat) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        accum_mem_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (bank_we),
            .waddr   (bank_waddr),
            .wdata   (bank_wdata),
            .re_a    (wr_go),
            .raddr_a (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .rdata_a (qa),
            .re_b    (rd_go),
            .raddr_b (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .rdata_b (qb)
        );

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = qb;
        assign rd_valid[i]                         = rd_vld_q;
        assign ovf[i]                              = ovf_q;
    end

endmodule

// File: tb/tb_accum_mem_arr.sv
// Directed bench for accum_mem_arr: overwrite, accumulate chains, saturation, read-first, clear and reset.
module tb_accum_mem_arr;

    localparam int unsigned WH    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              busy;
    logic [WH-1:0]     wr_en;
    logic [WH-1:0]     wr_accum;
    logic [WH*AW-1:0]  wr_addr;
    logic [WH*DW-1:0]  wr_data;
    logic [WH-1:0]     rd_en;
    logic [WH*AW-1:0]  rd_addr;
    logic [WH*DW-1:0]  rd_data;
    logic [WH-1:0]     rd_valid;
    logic [WH-1:0]     ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    accum_mem_arr #(
        .WIDTH_HEIGHT (WH),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_accum (wr_accum),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ovf      (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rd_word(input int ch);
        return rd_data[ch*DW +: DW];
    endfunction

    task automatic idle();
        wr_en    = '0;
        wr_accum = '0;
        rd_en    = '0;
        clear    = 1'b0;
    endtask

    task automatic set_wr(input int ch, input logic acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[ch]             = 1'b1;
        wr_accum[ch]          = acc;
        wr_addr[ch*AW +: AW]  = a;
        wr_data[ch*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int ch, input logic [AW-1:0] a);
        rd_en[ch]            = 1'b1;
        rd_addr[ch*AW +: AW] = a;
    endtask

    // Counts busy-high cycles starting from the cycle after the clear edge; bounded.
    task automatic wait_sweep(output int cnt, output logic saw_valid);
        int guard;
        cnt       = 1;
        saw_valid = 1'b0;
        guard     = 0;
        while (busy && guard < int'(DEPTH) + 20) begin
            wr_en = '1;
            rd_en = '1;
            clear = 1'b1;
            tick();
            if (busy) cnt++;
            if (rd_valid != '0) saw_valid = 1'b1;
            guard++;
        end
        idle();
    endtask

    initial begin
        int          busy_cnt;
        logic        saw_valid;
        logic [AW-1:0] addrs [6];

        rst_n   = 1'b0;
        idle();
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Overwrite ch0 addr 5, read two cycles later
        set_wr(0, 1'b0, 8'd5, 16'h0010);
        tick();
        idle();
        tick();
        set_rd(0, 8'd5);
        tick();
        chk("ow_rd_valid", 64'(rd_valid), 64'h1);
        chk("ow_rd_data", 64'(rd_word(0)), 64'h0010);
        idle();
        tick();
        chk("ow_valid_drop", 64'(rd_valid), 64'h0);
        chk("ow_data_hold", 64'(rd_word(0)), 64'h0010);

        // Back-to-back accumulate chain on ch1 addr 9: 0 +3 +4 +5
        set_wr(1, 1'b0, 8'd9, 16'h0000);
        tick();
        set_wr(1, 1'b1, 8'd9, 16'd3);
        tick();
        set_wr(1, 1'b1, 8'd9, 16'd4);
        tick();
        set_wr(1, 1'b1, 8'd9, 16'd5);
        tick();
        idle();
        tick();
        set_rd(1, 8'd9);
        tick();
        chk("chain_rd_data", 64'(rd_word(1)), 64'd12);
        chk("chain_rd_valid", 64'(rd_valid), 64'h2);
        chk("chain_no_ovf", 64'(ovf), 64'h0);
        idle();

        // Saturation on ch2: positive then negative limit
        set_wr(2, 1'b0, 8'd1, 16'h7FF0);
        tick();
        set_wr(2, 1'b1, 8'd1, 16'h0020);
        tick();
        set_wr(2, 1'b0, 8'd2, 16'h8000);
        tick();
        set_wr(2, 1'b1, 8'd2, 16'hFFFF);
        tick();
        idle();
        tick();
        chk("sat_ovf", 64'(ovf), 64'h4);
        set_rd(2, 8'd1);
        tick();
        chk("sat_pos", 64'(rd_word(2)), 64'h7FFF);
        set_rd(2, 8'd2);
        tick();
        chk("sat_neg", 64'(rd_word(2)), 64'h8000);
        idle();

        // Non-forwarded accumulate on ch0: 0x10 + 5 - 16 = 5
        set_wr(0, 1'b1, 8'd5, 16'd5);
        tick();
        idle();
        tick();
        set_wr(0, 1'b1, 8'd5, 16'hFFF0);
        tick();
        idle();
        tick();
        set_rd(0, 8'd5);
        tick();
        chk("acc_bank_path", 64'(rd_word(0)), 64'h0005);
        chk("acc_neg_no_ovf", 64'(ovf), 64'h4);
        idle();

        // Read-first on ch3 addr 2
        set_wr(3, 1'b0, 8'd2, 16'h1111);
        tick();
        idle();
        tick();
        set_wr(3, 1'b0, 8'd2, 16'h2222);
        tick();
        idle();
        set_rd(3, 8'd2);
        tick();
        chk("rf_old", 64'(rd_word(3)), 64'h1111);
        tick();
        chk("rf_new", 64'(rd_word(3)), 64'h2222);
        idle();

        // Clear sweep with requests on the accept cycle and during the sweep
        set_wr(0, 1'b0, 8'd5, 16'hBEEF);
        for (int c = 0; c < int'(WH); c++) set_rd(c, 8'd5);
        clear = 1'b1;
        chk("clr_busy_pre", 64'(busy), 64'd0);
        tick();
        chk("clr_busy_rise", 64'(busy), 64'd1);
        chk("clr_accept_no_valid", 64'(rd_valid), 64'h0);
        chk("clr_ovf_zero", 64'(ovf), 64'h0);
        wait_sweep(busy_cnt, saw_valid);
        chk("clr_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
        chk("clr_no_valid_in_sweep", 64'(saw_valid), 64'd0);
        chk("clr_busy_fall", 64'(busy), 64'd0);
        addrs[0] = 8'd0;
        addrs[1] = 8'd1;
        addrs[2] = 8'd2;
        addrs[3] = 8'd5;
        addrs[4] = 8'd9;
        addrs[5] = 8'd255;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < int'(WH); c++) set_rd(c, addrs[k]);
            tick();
            chk("clr_readback_data", 64'(rd_data), 64'd0);
            chk("clr_readback_valid", 64'(rd_valid), 64'hF);
        end
        idle();
        chk("clr_ovf_after", 64'(ovf), 64'h0);

        // Reset in the middle of a sweep
        set_wr(0, 1'b0, 8'd7, 16'h1234);
        tick();
        idle();
        tick();
        set_rd(0, 8'd7);
        tick();
        chk("pre_rst_data", 64'(rd_word(0)), 64'h1234);
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) begin
            rd_en = '1;
            tick();
        end
        chk("mid_sweep_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'h0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(busy), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("reclr_busy_rise", 64'(busy), 64'd1);
        wait_sweep(busy_cnt, saw_valid);
        chk("reclr_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
        chk("reclr_no_valid", 64'(saw_valid), 64'd0);
        set_rd(0, 8'd7);
        tick();
        chk("reclr_addr7", 64'(rd_word(0)), 64'd0);
        chk("reclr_valid", 64'(rd_valid), 64'h1);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/accum_mem_arr.md
# accum_mem_arr

Parametrised per-column output buffer for the systolic array with per-channel accumulate mode. Each of `WIDTH_HEIGHT` channels owns one bank that supports three operations:

- overwrite a word;
- read-modify-write a signed saturating partial sum into a word;
- read a word back with a valid strobe.

A single-pulse clear sweeps all banks to zero. The block sits between the array's column outputs and the result drain logic, and replaces the plain per-column output memories so that tiled matrix products can accumulate in place.

## Interface
Parameters:
- `WIDTH_HEIGHT`, 4: channel count, one per array column.
- `DATA_WIDTH`, 16: word width, signed two's complement.
- `ADDR_WIDTH`, 8: per-bank address width. Bank depth `DEPTH = 2**ADDR_WIDTH`.

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: single-cycle request to zero all banks.
- `busy` out 1: high while a clear sweep runs.
- `wr_en` in `WIDTH_HEIGHT`: per-channel write request.
- `wr_accum` in `WIDTH_HEIGHT`: per-channel mode. 1 = accumulate, 0 = overwrite. Sampled with `wr_en`.
- `wr_addr` in `WIDTH_HEIGHT*ADDR_WIDTH`: channel i at bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `wr_data` in `WIDTH_HEIGHT*DATA_WIDTH`: channel i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_en` in `WIDTH_HEIGHT`: per-channel read request.
- `rd_addr` in `WIDTH_HEIGHT*ADDR_WIDTH`: per-channel read address.
- `rd_data` out `WIDTH_HEIGHT*DATA_WIDTH`: per-channel read data.
- `rd_valid` out `WIDTH_HEIGHT`: `rd_data` of that channel is valid this cycle.
- `ovf` out `WIDTH_HEIGHT`: sticky per-channel saturation flag.

## Operation
Channels are fully independent, except that clear applies to all of them.

Write pipeline, per channel, applies to both modes:
- Stage A, cycle t: capture `wr_en`, `wr_accum`, `wr_addr` and `wr_data`; issue a synchronous read of the addressed word.
- Stage B, cycle t+1:
  - Overwrite: write `wr_data`.
  - Accumulate: write `sat(old + wr_data)`.
  - The write commits at the end of t+1.

Forwarding:
- In stage B, take `old` from the previous stage-B result when that result committed at the end of the prior cycle to the same address.
- Otherwise take `old` from the bank.
- Back-to-back operations to one address therefore chain correctly at full rate.

Arithmetic:
- Add in `DATA_WIDTH+1` bits.
- Saturate to `2**(DATA_WIDTH-1)-1` or `-2**(DATA_WIDTH-1)`.
- Any saturation sets `ovf[i]`. Overwrites never saturate.

Reads:
- `rd_en[i]` at cycle t gives `rd_data`/`rd_valid` at t+1. Read-first: a write committing at the end of t is not visible.
- `rd_data` holds its last value when `rd_valid` is low.

Clear FSM, states IDLE and SWEEP:
- IDLE→SWEEP when `clear=1` in IDLE. In the accept cycle t:
  - `ovf` is zeroed;
  - new `wr_en`/`rd_en` are ignored;
  - a stage-B write already in flight still commits.
- SWEEP: a counter writes 0 to address k of every bank at cycle t+1+k, for k = 0..DEPTH-1. `busy` is high throughout.
- SWEEP→IDLE after address DEPTH-1.
- While in SWEEP: `wr_en`, `rd_en` and `clear` are ignored, and `rd_valid` is 0.

Reset and bank contents:
- Reset forces IDLE and clears the pipeline registers, `busy`, `rd_valid`, `ovf` and `rd_data` to 0.
- Bank contents are not reset; software issues `clear`.
- Reset mid-sweep aborts the sweep.

## Timing
- Write latency: 2 cycles, request to commit. A read issued at t+2 or later sees the new value.
- Read latency: 1 cycle.
- Throughput: one write and one read per channel per cycle.
- Clear: `busy` rises at t+1 and falls at t+DEPTH+1. The first request honoured is at t+DEPTH+1.

## Structure
- Package `accum_mem_pkg`: `DATA_WIDTH`/`ADDR_WIDTH` defaults, a saturating-add function, and the FSM state enum.
- Sub-module `accum_mem_bank`: one 2R1W inferred RAM with synchronous read-first ports, one instance per channel via generate.
- The top level holds the per-channel stage-A/B pipeline with forwarding, the shared clear FSM and its counter, and the `ovf` flags.

## Test plan
- Overwrite ch0 addr 5 with 0x0010, then read addr 5 at t+2 -> `rd_data`[ch0]=0x0010 and `rd_valid`[0]=1, one cycle after `rd_en`.
- Accumulate +3, +4, +5 to ch1 addr 9 on consecutive cycles, starting from 0 -> final read returns 12. Exercises forwarding.
- Accumulate 0x7FF0 + 0x0020 on ch2 -> stored 0x7FFF and `ovf`[2]=1. Then 0x8000 + (-1) -> 0x8000.
- Read ch3 addr 2 in the same cycle its overwrite commits -> old value returned; the following read returns the new value.
- Clear with DEPTH=256 -> `busy` high for exactly 256 cycles, requests during the sweep produce no `rd_valid`, all addresses read 0 afterwards, `ovf` is 0.
- Assert `rst_n` low mid-sweep -> `busy`=0 immediately and all outputs 0; after release, a new clear completes normally.
